// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, the
// outstanding-read tracker states and PC arithmetic.
package fetch;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } tracker_state_t;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/pipeline_status.sv
// Pipeline handshake encodings shared by every stage: forwards validity and
// backwards control (consume / hold / redirect).
package pipeline_status;

    typedef enum logic {
        FWD_BUBBLE = 1'b0,
        FWD_READY  = 1'b1
    } forwards_t;

    typedef enum logic [1:0] {
        BWD_READY = 2'd0,
        BWD_STALL = 2'd1,
        BWD_JUMP  = 2'd2
    } backwards_t;

endpackage

// File: rtl/fetch_stage_skid.sv
// Two-entry output buffer (out + skid) between instruction memory responses
// and decode; flush drops both entries, consume advances out from skid or load.
module fetch_skid_buffer
    import fetch::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        consume_i,
    input  logic        load_i,
    input  logic [31:0] load_instr_i,
    input  logic [31:0] load_pc_i,
    output logic        out_valid_o,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_npc_o,
    output logic        skid_valid_o
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_npc_q, out_npc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_npc_d    = out_npc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume_i) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                out_npc_d    = next_word(skid_pc_q);
                skid_valid_d = 1'b0;
            end else if (load_i) begin
                out_valid_d = 1'b1;
                out_instr_d = load_instr_i;
                out_pc_d    = load_pc_i;
                out_npc_d   = next_word(load_pc_i);
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (load_i) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_instr_d = load_instr_i;
                out_pc_d    = load_pc_i;
                out_npc_d   = next_word(load_pc_i);
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = load_instr_i;
                skid_pc_d    = load_pc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= 32'd0;
            out_npc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_npc_q    <= out_npc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // An empty output shows a NOP while the PCs keep their last values.
    assign out_valid_o  = out_valid_q;
    assign out_instr_o  = out_valid_q ? out_instr_q : NOP_INSTR;
    assign out_pc_o     = out_pc_q;
    assign out_npc_o    = out_npc_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, keeps at most one memory read in
// flight and hands fetched words to decode through a two-entry buffer.
module fetch_stage
    import fetch::*;
    import pipeline_status::*;
#(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instruction_out,
    output logic [31:0] program_counter_out,
    output logic [31:0] next_program_counter_out,
    output forwards_t   status_forwards_out,
    input  backwards_t  status_backwards_in,
    input  logic [31:0] jump_address_backwards_in
);

    tracker_state_t state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    req_addr_q, req_addr_d;

    logic jump;
    logic resp_valid;
    logic resp_keep;
    logic consume;
    logic accept;
    logic skid_fill;
    logic out_valid;
    logic skid_valid;

    assign jump       = (status_backwards_in == BWD_JUMP);
    assign resp_valid = (state_q == WAIT) && imem_rvalid_in;
    assign resp_keep  = resp_valid && !jump;
    assign consume    = out_valid && (status_backwards_in == BWD_READY);

    // A response about to land in skid leaves no room for another read, so
    // it blocks a new request just as a full skid does.
    assign skid_fill    = resp_valid && out_valid && !consume;
    assign imem_req_out = !rst && !jump && !skid_valid && !skid_fill &&
                          ((state_q == IDLE) || resp_valid);
    assign accept        = imem_req_out && imem_ready_in;
    assign imem_addr_out = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;

        if (jump) begin
            pc_d = jump_address_backwards_in & 32'hFFFF_FFFC;
            case (state_q)
                WAIT:    state_d = imem_rvalid_in ? IDLE : DISCARD;
                DISCARD: state_d = imem_rvalid_in ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else if (accept) begin
            req_addr_d = pc_q;
            pc_d       = next_word(pc_q);
            state_d    = WAIT;
        end else if ((state_q != IDLE) && imem_rvalid_in) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_ADDRESS;
            req_addr_q <= RESET_ADDRESS;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_skid_buffer u_buffer (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (jump),
        .consume_i    (consume),
        .load_i       (resp_keep),
        .load_instr_i (imem_rdata_in),
        .load_pc_i    (req_addr_q),
        .out_valid_o  (out_valid),
        .out_instr_o  (instruction_out),
        .out_pc_o     (program_counter_out),
        .out_npc_o    (next_program_counter_out),
        .skid_valid_o (skid_valid)
    );

    assign status_forwards_out = out_valid ? FWD_READY : FWD_BUBBLE;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: an in-order memory model with
// variable latency and a program-order model of the delivered instruction stream.
module tb_fetch_stage;
    import pipeline_status::*;

    localparam logic [31:0] RST_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] npc_o;
    forwards_t   status_fwd;
    backwards_t  status_bwd;
    logic [31:0] jaddr;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_ADDRESS(RST_ADDR)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .imem_req_out              (imem_req),
        .imem_addr_out             (imem_addr),
        .imem_ready_in             (imem_ready),
        .imem_rvalid_in            (imem_rvalid),
        .imem_rdata_in             (imem_rdata),
        .instruction_out           (instr_o),
        .program_counter_out       (pc_o),
        .next_program_counter_out  (npc_o),
        .status_forwards_out       (status_fwd),
        .status_backwards_in       (status_bwd),
        .jump_address_backwards_in (jaddr)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int n_accept  = 0;
    int n_consume = 0;
    int cyc       = 0;
    int lat_lo    = 1;
    int lat_hi    = 1;
    int rst_seen  = 0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    bit          stale_inject = 1'b0;
    bit          chk_req_next = 1'b0;
    logic [31:0] chk_req_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit before the rising edge.
    task automatic step(input backwards_t b, input logic [31:0] ja, input bit rdy, input bit r);
        logic [31:0] tgt;
        bit          stale_now;
        stale_now  = 1'b0;
        rst        = r;
        status_bwd = b;
        jaddr      = ja;
        imem_ready = rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        tgt = ja & 32'hFFFF_FFFC;
        if (r) begin
            pend_addr.delete();
            pend_due.delete();
            exp_q.delete();
            exp_q.push_back(RST_ADDR);
            exp_fetch = RST_ADDR;
        end else if (stale_inject) begin
            imem_rvalid  = 1'b1;
            imem_rdata   = 32'hDEAD_BEEF;
            imem_ready   = 1'b0;
            stale_inject = 1'b0;
            stale_now    = 1'b1;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend_addr[0]);
        end
        if (b == BWD_JUMP && !r) begin
            exp_q.delete();
            exp_q.push_back(tgt);
            exp_fetch = tgt;
        end
        #4;
        if (chk_req_next && !r && b != BWD_JUMP) begin
            chk("req_after_jump_rvalid", 32'(imem_req), 32'd1);
            chk("addr_after_jump_rvalid", imem_addr, chk_req_addr);
        end
        chk_req_next = 1'b0;
        if (r) begin
            chk("req_in_reset", 32'(imem_req), 32'd0);
            if (rst_seen > 0) begin
                chk("reset_status", 32'(status_fwd == FWD_BUBBLE), 32'd1);
                chk("reset_instr", instr_o, NOP_WORD);
                chk("reset_pc", pc_o, 32'd0);
                chk("reset_npc", npc_o, 32'd0);
                chk("reset_addr", imem_addr, RST_ADDR);
            end
            rst_seen++;
        end else begin
            rst_seen = 0;
        end
        if (b == BWD_JUMP && !r) begin
            chk("req_on_jump", 32'(imem_req), 32'd0);
            if (imem_rvalid) begin
                chk_req_next = 1'b1;
                chk_req_addr = tgt;
            end
        end
        if (imem_rvalid && !stale_now && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (imem_req && imem_ready && !r) begin
            chk("one_outstanding", 32'(pend_addr.size()), 32'd0);
            chk("fetch_addr", imem_addr, exp_fetch);
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            exp_fetch = exp_fetch + 32'd4;
            n_accept++;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Monitor: checks every delivered instruction against the program-order model.
    initial begin
        bit          hold_v;
        logic [31:0] hold_pc;
        logic [31:0] hold_ins;
        logic [31:0] e;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst !== 1'b0) begin
                hold_v = 1'b0;
                continue;
            end
            if (hold_v) begin
                chk("stall_hold_valid", 32'(status_fwd == FWD_READY), 32'd1);
                chk("stall_hold_pc", pc_o, hold_pc);
                chk("stall_hold_instr", instr_o, hold_ins);
            end
            hold_v = 1'b0;
            if (status_fwd == FWD_READY) begin
                if (status_bwd == BWD_READY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL scoreboard_empty: got pc %08h, expected nothing", pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", pc_o, e);
                        chk("out_instr", instr_o, memf(e));
                        chk("out_npc", npc_o, e + 32'd4);
                        exp_q.push_back(e + 32'd4);
                        n_consume++;
                    end
                end else if (status_bwd == BWD_STALL) begin
                    hold_v   = 1'b1;
                    hold_pc  = pc_o;
                    hold_ins = instr_o;
                end
            end else begin
                chk("bubble_nop", instr_o, NOP_WORD);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          a0;
        int          k;
        bit          found;
        backwards_t  rb;
        logic [31:0] ja;
        rst = 1'b1;
        status_bwd = BWD_READY;
        jaddr = 32'd0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        exp_fetch = RST_ADDR;
        exp_q.push_back(RST_ADDR);
        @(negedge clk);
        repeat (3) step(BWD_READY, 32'd0, 1'b1, 1'b1);

        // Streaming from reset across the 32-bit wrap, k = 1.
        lat_lo = 1; lat_hi = 1;
        c0 = n_consume;
        repeat (20) step(BWD_READY, 32'd0, 1'b1, 1'b0);
        chk("stream_throughput", 32'((n_consume - c0) >= 17), 32'd1);

        // Stall with out holding 0x200.
        step(BWD_JUMP, 32'h200, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (status_fwd == FWD_READY) begin found = 1'b1; break; end
            step(BWD_READY, 32'd0, 1'b1, 1'b0);
        end
        chk("stall_setup_valid", 32'(found), 32'd1);
        chk("stall_out_pc", pc_o, 32'h200);
        a0 = n_accept;
        repeat (5) step(BWD_STALL, 32'd0, 1'b1, 1'b0);
        chk("stall_extra_reads", 32'((n_accept - a0) <= 1), 32'd1);
        chk("stall_out_pc_after", pc_o, 32'h200);
        repeat (10) step(BWD_READY, 32'd0, 1'b1, 1'b0);

        // Jump while a read is outstanding, k = 3.
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pend_due.size() > 0 && pend_due[0] > cyc) begin found = 1'b1; break; end
            step(BWD_READY, 32'd0, 1'b1, 1'b0);
        end
        chk("discard_setup", 32'(found), 32'd1);
        step(BWD_JUMP, 32'h403, 1'b1, 1'b0);
        c0 = n_consume;
        repeat (15) step(BWD_READY, 32'd0, 1'b1, 1'b0);
        chk("discard_progress", 32'(n_consume > c0), 32'd1);

        // Jump in the same cycle as a response, k = 1.
        lat_lo = 1; lat_hi = 1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin found = 1'b1; break; end
            step(BWD_READY, 32'd0, 1'b1, 1'b0);
        end
        chk("jump_rvalid_setup", 32'(found), 32'd1);
        step(BWD_JUMP, 32'h800, 1'b1, 1'b0);
        repeat (8) step(BWD_READY, 32'd0, 1'b1, 1'b0);

        // Random traffic.
        lat_lo = 1; lat_hi = 4;
        repeat (1500) begin
            k = $urandom_range(0, 99);
            rb = (k < 70) ? BWD_READY : ((k < 88) ? BWD_STALL : BWD_JUMP);
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(rb, ja, ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Reset while a read is outstanding; a stale response follows reset.
        lat_lo = 4; lat_hi = 4;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pend_due.size() > 0 && pend_due[0] > cyc) begin found = 1'b1; break; end
            step(BWD_READY, 32'd0, 1'b1, 1'b0);
        end
        chk("reset_mid_read_setup", 32'(found), 32'd1);
        repeat (2) step(BWD_READY, 32'd0, 1'b1, 1'b1);
        stale_inject = 1'b1;
        lat_lo = 1; lat_hi = 1;
        c0 = n_consume;
        repeat (12) step(BWD_READY, 32'd0, 1'b1, 1'b0);
        chk("reset_recovery_progress", 32'(n_consume > c0), 32'd1);

        chk("total_delivered", 32'(n_consume > 200), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
